// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, decode handshake and redirect.
// master = fetch_unit side, slave = memory/decode/execute side.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_rvalid, imem_rdata, instr_ready, redirect_valid, redirect_target
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_rvalid, imem_rdata, instr_ready, redirect_valid, redirect_target
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem fetch, prefetch FIFO to decode, redirect flush.
// Optional macro FETCH_JUMP_PREDECODE_EN follows J/JAL targets at fetch time.
module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  fetch_unit_if.master bus
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {ISSUE, WAIT, DISCARD} state_t;

  state_t        state, state_n;
  logic [31:0]   pc, pc_n, fetch_pc, fetch_pc_n;
  logic [31:0]   seq_pc, next_pc, target;
  logic [31:0]   buf_instr [DEPTH];
  logic [31:0]   buf_pc    [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          push, pop, flush;

  assign seq_pc = fetch_pc + 32'd4;
  assign target = {bus.redirect_target[31:2], 2'b00};

`ifdef FETCH_JUMP_PREDECODE_EN
  always_comb begin
    next_pc = seq_pc;
    if (bus.imem_rdata[31:26] == 6'b000010 || bus.imem_rdata[31:26] == 6'b000011)
      next_pc = {seq_pc[31:28], bus.imem_rdata[25:0], 2'b00};
  end
`else
  assign next_pc = seq_pc;
`endif

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    fetch_pc_n   = fetch_pc;
    push         = 1'b0;
    flush        = 1'b0;
    bus.imem_req = 1'b0;
    if (!reset) begin
      unique case (state)
        ISSUE: begin
          if (bus.redirect_valid) begin
            pc_n  = target;
            flush = 1'b1;
          end else if (count != FULL) begin
            bus.imem_req = 1'b1;
            fetch_pc_n   = pc;
            state_n      = WAIT;
          end
        end
        WAIT: begin
          // A redirect beats a same-cycle response; the response is simply not pushed.
          if (bus.redirect_valid) begin
            pc_n    = target;
            flush   = 1'b1;
            state_n = bus.imem_rvalid ? ISSUE : DISCARD;
          end else if (bus.imem_rvalid) begin
            push    = 1'b1;
            pc_n    = next_pc;
            state_n = ISSUE;
          end
        end
        DISCARD: begin
          if (bus.redirect_valid) begin
            pc_n  = target;
            flush = 1'b1;
          end
          if (bus.imem_rvalid) state_n = ISSUE;
        end
        default: state_n = ISSUE;
      endcase
    end
  end

  assign bus.imem_addr   = pc;
  assign bus.instr_valid = !reset && (count != '0);
  assign bus.instr       = bus.instr_valid ? buf_instr[rd_ptr] : '0;
  assign bus.instr_pc    = bus.instr_valid ? buf_pc[rd_ptr]    : '0;
  assign pop             = bus.instr_valid && bus.instr_ready && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ISSUE;
      pc       <= RESET_PC;
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      fetch_pc <= fetch_pc_n;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr] <= bus.imem_rdata;
      buf_pc[wr_ptr]    <= fetch_pc;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-programmable memory model, program-order scoreboard,
// directed vector table, multi-cycle corner sequences and a randomized phase.
module tb_fetch_unit;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk;
  logic reset;
  fetch_unit_if bus();

  fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int errors = 0;
  int pops   = 0;

  // Stimulus shadows, applied to the DUT at the next negedge.
  logic        rst_s   = 1'b1;
  logic        ready_s = 1'b1;
  logic        redir_s = 1'b0;
  logic [31:0] tgt_s   = '0;
  int          lat_s   = 1;
  logic        redir_on_rv = 1'b0;
  logic [31:0] rv_tgt  = '0;
  logic        jump_en = 1'b0;

  // Memory model state.
  logic        pend = 1'b0;
  int          cnt  = 0;
  logic [31:0] pend_addr = '0;
  logic [31:0] req_log [$];

  // Scoreboard state.
  logic [31:0] exp_pc = RESET_PC;
  logic        prev_redir = 1'b0;

  typedef struct {
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;
  vec_t vecs [9];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (jump_en && a == 32'h0000_0008) return 32'h0800_0040;
    return a;
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] p);
    logic [31:0] s;
    s = p + 32'd4;
`ifdef FETCH_JUMP_PREDECODE_EN
    begin
      logic [31:0] d;
      d = memfn(p);
      if (d[31:27] == 5'b00001) return {s[31:28], d[25:0], 2'b00};
    end
`endif
    return s;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    errors++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  task automatic monitor();
    if (rst_s) begin
      chk1("rst_req", bus.imem_req, 1'b0);
      chk1("rst_valid", bus.instr_valid, 1'b0);
      exp_pc     = RESET_PC;
      prev_redir = 1'b0;
      return;
    end
    if (prev_redir) chk1("flush_valid", bus.instr_valid, 1'b0);
    if (bus.instr_valid) begin
      chk32("head_pc", bus.instr_pc, exp_pc);
      chk32("head_data", bus.instr, memfn(bus.instr_pc));
    end else begin
      chk32("empty_instr", bus.instr, 32'h0);
      chk32("empty_pc", bus.instr_pc, 32'h0);
    end
    if (bus.imem_req) chk32("addr_align", 32'(bus.imem_addr[1:0]), 32'h0);
    if (bus.redirect_valid) begin
      exp_pc = bus.redirect_target & 32'hFFFF_FFFC;
    end else if (bus.instr_valid && bus.instr_ready) begin
      exp_pc = model_next(exp_pc);
      pops++;
    end
    prev_redir = bus.redirect_valid;
  endtask

  task automatic cycle();
    @(negedge clk);
    reset           = rst_s;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = $urandom();
    if (pend) begin
      cnt--;
      if (cnt == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = memfn(pend_addr);
        pend = 1'b0;
      end
    end
    bus.instr_ready     = ready_s;
    bus.redirect_valid  = redir_s;
    bus.redirect_target = tgt_s;
    redir_s = 1'b0;
    if (redir_on_rv && bus.imem_rvalid) begin
      bus.redirect_valid  = 1'b1;
      bus.redirect_target = rv_tgt;
      redir_on_rv = 1'b0;
    end
    #1;
    monitor();
    if (bus.imem_req) begin
      chk1("one_outstanding", pend, 1'b0);
      pend      = 1'b1;
      cnt       = (lat_s == 0) ? int'($urandom_range(1, 4)) : lat_s;
      pend_addr = bus.imem_addr;
      req_log.push_back(bus.imem_addr);
    end
  endtask

  task automatic do_reset();
    rst_s = 1'b1;
    pend  = 1'b0;
    cycle();
    cycle();
    rst_s = 1'b0;
    req_log.delete();
  endtask

  task automatic wait_req(input string name, input logic [31:0] exp);
    req_log.delete();
    for (int i = 0; i < 50 && req_log.size() == 0; i++) cycle();
    if (req_log.size() == 0) timeout_fail(name);
    else chk32(name, req_log[0], exp);
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp);
    for (int i = 0; i < 50 && !bus.instr_valid; i++) cycle();
    if (!bus.instr_valid) timeout_fail(name);
    else chk32(name, bus.instr_pc, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset               = 1'b1;
    bus.imem_rvalid     = 1'b0;
    bus.imem_rdata      = '0;
    bus.instr_ready     = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;

    vecs[0] = '{1'b1, 1'b1, 32'h0,  1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 32'h4,  1'b1, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 32'h8,  1'b1, 32'h4};
    vecs[5] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    vecs[6] = '{1'b1, 1'b1, 32'hC,  1'b1, 32'h8};
    vecs[7] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0};
    vecs[8] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'hC};

    // Sequential fetch, L=1, decode always ready.
    lat_s = 1;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      ready_s = vecs[i].ready;
      cycle();
      chk1("vec_req", bus.imem_req, vecs[i].exp_req);
      if (vecs[i].exp_req) chk32("vec_addr", bus.imem_addr, vecs[i].exp_addr);
      chk1("vec_valid", bus.instr_valid, vecs[i].exp_valid);
      chk32("vec_pc", bus.instr_pc, vecs[i].exp_pc);
    end

    // Backpressure fills the FIFO, then drains back-to-back.
    ready_s = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) cycle();
    chk32("bp_nreq", 32'(req_log.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < req_log.size()) chk32("bp_addr", req_log[i], 32'(i * 4));
    chk1("bp_idle", bus.imem_req, 1'b0);
    ready_s = 1'b1;
    req_log.delete();
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk1("bp_drain_valid", bus.instr_valid, 1'b1);
      chk32("bp_drain_pc", bus.instr_pc, 32'(i * 4));
    end
    if (req_log.size() != 0) chk32("bp_resume", req_log[0], 32'h10);
    else timeout_fail("bp_resume");

    // Redirect while waiting on a L=3 fetch.
    ready_s = 1'b0;
    lat_s   = 3;
    do_reset();
    for (int i = 0; i < 30 && req_log.size() < 2; i++) cycle();
    if (req_log.size() < 2) timeout_fail("wait_second_req");
    redir_s = 1'b1;
    tgt_s   = 32'h0000_0100;
    cycle();
    cycle();
    chk1("wait_redir_empty", bus.instr_valid, 1'b0);
    wait_req("wait_redir_addr", 32'h100);
    ready_s = 1'b1;
    wait_valid("wait_redir_first_pc", 32'h100);

    // Redirect coinciding with the response.
    lat_s = 2;
    do_reset();
    for (int i = 0; i < 3; i++) cycle();
    redir_on_rv = 1'b1;
    rv_tgt      = 32'h0000_0200;
    for (int i = 0; i < 20 && redir_on_rv; i++) cycle();
    if (redir_on_rv) begin
      timeout_fail("rv_redir_hit");
      redir_on_rv = 1'b0;
    end
    wait_req("rv_redir_addr", 32'h200);
    wait_valid("rv_redir_first_pc", 32'h200);

    // Jump at pc 0x8 to target 26'h40.
    jump_en = 1'b1;
    lat_s   = 1;
    do_reset();
    for (int i = 0; i < 40 && req_log.size() < 4; i++) cycle();
    if (req_log.size() < 4) timeout_fail("jump_next_addr");
`ifdef FETCH_JUMP_PREDECODE_EN
    else chk32("jump_next_addr", req_log[3], 32'h100);
`else
    else chk32("jump_next_addr", req_log[3], 32'hC);
`endif
    for (int i = 0; i < 10; i++) cycle();
    jump_en = 1'b0;

    // Redirect from ISSUE to the top word, then PC wraps to 0.
    lat_s = 1;
    do_reset();
    redir_s = 1'b1;
    tgt_s   = 32'hFFFF_FFFD;
    cycle();
    chk1("issue_redir_suppress", bus.imem_req, 1'b0);
    cycle();
    chk1("wrap_req", bus.imem_req, 1'b1);
    chk32("wrap_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
    cycle();
    cycle();
    chk1("wrap_req2", bus.imem_req, 1'b1);
    chk32("wrap_addr_zero", bus.imem_addr, 32'h0);

    // Reset while a fetch is outstanding; response arrives just after.
    lat_s = 2;
    do_reset();
    cycle();
    rst_s = 1'b1;
    cycle();
    rst_s = 1'b0;
    cycle();
    chk1("late_rst_req", bus.imem_req, 1'b1);
    chk32("late_rst_addr", bus.imem_addr, RESET_PC);
    chk1("late_rst_valid0", bus.instr_valid, 1'b0);
    cycle();
    chk1("late_rst_valid1", bus.instr_valid, 1'b0);
    wait_valid("late_rst_first_pc", RESET_PC);

    // Randomized traffic against the scoreboard.
    lat_s = 0;
    do_reset();
    pops = 0;
    for (int i = 0; i < 3000; i++) begin
      ready_s = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        redir_s = 1'b1;
        tgt_s   = $urandom() & 32'h0000_FFFF;
      end
      cycle();
    end
    chk1("rand_progress", pops > 100, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
